// File: rtl/pll_reset_sequencer.sv
// PLL clock-domain bring-up: lock filter, reset release, clock-enable strobes.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_WAIT_LOCK | waiting for synchronised lock; design held in reset
// S_FILTER    | counting consecutive locked cycles up to LOCK_FILTER
// S_HOLD      | lock stable; keeping reset asserted for RST_HOLD cycles
// S_RUN       | reset released, ready high, clock-enable strobes running
module pll_reset_sequencer #(
   parameter int NUM_CE      = 2,
   parameter int DIV_W       = 8,
   parameter int LOCK_FILTER = 16,
   parameter int RST_HOLD    = 64
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    pll_locked,
   input  logic [NUM_CE*DIV_W-1:0] div,
   input  logic                    clear_lost,
   output logic                    rst_out_n,
   output logic                    ready,
   output logic [NUM_CE-1:0]       ce,
   output logic                    lost_lock
);

   localparam int LF_W  = $clog2(LOCK_FILTER) + 1;
   localparam int RH_W  = $clog2(RST_HOLD) + 1;
   localparam int CNT_W = (LF_W > RH_W) ? LF_W : RH_W;

   // Terminal counts: the transition happens on the edge where the count would reach the limit.
   localparam logic [CNT_W-1:0] LF_LAST = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] RH_LAST = CNT_W'(RST_HOLD - 1);

   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_FILTER    = 2'd1,
      S_HOLD      = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_sync1;
   logic               r_sync2;
   logic               w_lock_s;
   logic               r_run;
   logic               w_run_nxt;
   logic               r_lost;

   assign w_lock_s  = r_sync2;
   assign w_run_nxt = (w_state_nxt == S_RUN);
   assign rst_out_n = r_run;
   assign ready     = r_run;
   assign lost_lock = r_lost;

   // Two-flop synchroniser for the asynchronous PLL lock indication.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   // Next-state and shared filter/hold counter; any lock drop restarts from scratch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      case (r_state)
         S_WAIT_LOCK: begin
            if (w_lock_s) w_state_nxt = S_FILTER;
         end
         S_FILTER: begin
            if (!w_lock_s)              w_state_nxt = S_WAIT_LOCK;
            else if (r_cnt == LF_LAST)  w_state_nxt = S_HOLD;
            else                        w_cnt_nxt   = r_cnt + CNT_W'(1);
         end
         S_HOLD: begin
            if (!w_lock_s)              w_state_nxt = S_WAIT_LOCK;
            else if (r_cnt == RH_LAST)  w_state_nxt = S_RUN;
            else                        w_cnt_nxt   = r_cnt + CNT_W'(1);
         end
         S_RUN: begin
            if (!w_lock_s) w_state_nxt = S_WAIT_LOCK;
         end
         default: w_state_nxt = S_WAIT_LOCK;
      endcase
   end

   // State, counter, registered run flag and sticky lost-lock (set wins over clear).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_WAIT_LOCK;
         r_cnt   <= '0;
         r_run   <= 1'b0;
         r_lost  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_run   <= w_run_nxt;
         if ((r_state == S_RUN) && !w_lock_s) r_lost <= 1'b1;
         else if (clear_lost)                  r_lost <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
      logic [DIV_W-1:0] r_ce_cnt;
      logic [DIV_W-1:0] r_ce_dl;
      logic             w_strobe;

      assign w_strobe = r_run && (r_ce_cnt == r_ce_dl);
      assign ce[i]    = w_strobe;

      // Divisor is only re-latched at a period boundary, so periods are never cut short or stretched.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            r_ce_cnt <= '0;
            r_ce_dl  <= '0;
         end else if (!r_run || !w_run_nxt) begin
            r_ce_cnt <= '0;
            r_ce_dl  <= div[i*DIV_W +: DIV_W];
         end else if (w_strobe) begin
            r_ce_cnt <= '0;
            r_ce_dl  <= div[i*DIV_W +: DIV_W];
         end else begin
            r_ce_cnt <= r_ce_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Parametrised clock-domain bring-up block that sits directly behind the board PLL wrapper, in the PLL output clock domain.
- Filters the PLL lock indication and releases the design reset only after lock is stable for a programmable number of cycles.
- Drives NUM_CE programmable clock-enable strobes so slower subsystems run off one PLL clock without extra PLL outputs.
- Detects loss of lock and re-asserts reset.

Parameters:
- NUM_CE, 2, number of clock-enable channels (1..8)
- DIV_W, 8, width of each divisor field
- LOCK_FILTER, 16, consecutive synchronised-lock cycles required before the hold phase (>=1)
- RST_HOLD, 64, cycles the reset stays asserted after the filter passes (>=1)

Ports:
- clock  in  1  PLL output clock; the only clock
- reset_n  in  1  asynchronous active-low reset
- pll_locked  in  1  raw PLL LOCK, asynchronous to clock
- div  in  NUM_CE*DIV_W  per-channel divisor d; channel i uses bits [i*DIV_W +: DIV_W]
- clear_lost  in  1  synchronous clear of lost_lock
- rst_out_n  out  1  design reset; asserts asynchronously on reset_n, deasserts synchronously to clock
- ready  out  1  high exactly when state is RUN
- ce  out  NUM_CE  one-cycle clock-enable strobes
- lost_lock  out  1  sticky: lock dropped while in RUN

Behaviour:
- reset_n low, asynchronous: state=WAIT_LOCK, both sync flops=0, all counters=0, rst_out_n=0, ready=0, ce=0, lost_lock=0.
- pll_locked passes through a 2-flop synchroniser; its output is lock_s. No other path uses pll_locked.
- WAIT_LOCK: filter counter=0. When lock_s=1, go to FILTER.
- FILTER:
  - Counter increments each cycle lock_s=1.
  - lock_s=0 returns to WAIT_LOCK and clears the counter.
  - Counter reaching LOCK_FILTER goes to HOLD and clears the counter.
- HOLD:
  - Counter increments each cycle.
  - lock_s=0 returns to WAIT_LOCK.
  - Counter reaching RST_HOLD goes to RUN.
- RUN: rst_out_n=1, ready=1 (both registered, first high on the edge that enters RUN).
  - lock_s=0 goes to WAIT_LOCK.
  - On that same edge: rst_out_n=0, ready=0, ce=0, lost_lock=1.
- Latency: with pll_locked held high, rst_out_n rises exactly 2+LOCK_FILTER+RST_HOLD rising edges after the first edge that samples pll_locked=1.
- Any lock glitch of at least one synchronised cycle restarts the full sequence. Partial counts are never kept.
- Counter widths are sized by $clog2 of the respective parameter + 1. No wrap is possible.
- lost_lock:
  - Set has priority over clear_lost when both occur in the same cycle.
  - Only drops from RUN set it; drops in FILTER or HOLD do not.
- CE channel i:
  - Counter cnt_i and latched divisor dl_i.
  - Outside RUN: cnt_i=0, ce[i]=0, dl_i reloaded from div every cycle.
  - In RUN: ce[i]=1 in the cycle where cnt_i==dl_i, and cnt_i then returns to 0 and dl_i reloads from div. Otherwise cnt_i increments.
  - Period is dl_i+1 cycles. d=0 gives ce[i] high every RUN cycle.
  - First strobe occurs in RUN cycle index d (0-based, cycle 0 = first cycle ready=1).
  - A div change mid-period takes effect only after the current period's strobe. No short or extended period is allowed.
  - Channels are fully independent.
  - d = 2^DIV_W-1 gives period 2^DIV_W with no overflow.
- reset_n asserted mid-RUN: outputs return to reset values immediately (asynchronously); rst_out_n goes low without waiting for a clock.

Test Plan:
- LOCK_FILTER=4, RST_HOLD=8, pll_locked rises and stays high -> rst_out_n and ready rise exactly 14 edges later; ce=0 before that.
- Same params, pll_locked low for 1 cycle during FILTER count 3 and again during HOLD count 5 -> each drop returns to WAIT_LOCK; rst_out_n rises 14 edges after the final rise; lost_lock stays 0.
- In RUN with div ch0=0, ch1=3 -> ce[0] high every cycle; ce[1] high at RUN cycles 3, 7, 11; change ch1 to 1 at cycle 5 -> next strobes at cycles 7, 9, 11.
- In RUN, drop pll_locked for 3 cycles -> 2 edges later rst_out_n=0, ready=0, ce=0, lost_lock=1. Re-lock restarts the full 14-cycle sequence. lost_lock stays 1 until clear_lost; clear_lost in the same cycle as a new drop leaves lost_lock=1.
- Assert reset_n low between clock edges while in RUN -> rst_out_n, ready, ce, lost_lock go to 0 before the next edge. Release reset_n with pll_locked high -> the sequence restarts from WAIT_LOCK.
- DIV_W=4, div=15 -> ce period is exactly 16 cycles over 4 periods with no glitch at the counter wrap.
